// File: rtl/mem_access_unit_if.sv
// Request, response and RAM-pin bundle for the load/store sequencer.
// No logic of its own; all timing comes from mem_access_unit.
// The unit takes the slave side; the execution unit and RAM take the master side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [19:0] req_addr;
  logic [19:0] req_wdata;
  logic [19:0] ds_base;
  logic        rsp_valid;
  logic [19:0] rsp_data;
  logic        rsp_viol;
  logic [6:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic        mem_readsig;
  logic        mem_writesig;
  logic        mem_control;
  logic [19:0] mem_rdata;
  logic [19:0] ma_count;
  logic        viol_flag;
  logic        viol_clear;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, ds_base, mem_rdata, viol_clear,
    input  req_ready, rsp_valid, rsp_data, rsp_viol, mem_addr, mem_wdata,
           mem_readsig, mem_writesig, mem_control, ma_count, viol_flag
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ds_base, mem_rdata, viol_clear,
    output req_ready, rsp_valid, rsp_data, rsp_viol, mem_addr, mem_wdata,
           mem_readsig, mem_writesig, mem_control, ma_count, viol_flag
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the 64-word RAM: LDD/STD/LDI/STI with DS-relative, range-checked addressing.
// Latency from accept edge k to response: STD k+1, LDD k+2, STI k+3, LDI k+4, violation k or k+2.
// Takes one request at a time (req_ready only in IDLE); the one-cycle response pulse has no backpressure.
module mem_access_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  mem_access_unit_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRD   = 3'd1;
  localparam logic [2:0] S_PWAIT = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_VIOL  = 3'd7;

  localparam logic [1:0]  OP_LDD = 2'b00;
  localparam logic [1:0]  OP_STD = 2'b01;
  localparam logic [19:0] LIMIT  = 20'(MEM_WORDS);
  localparam logic [19:0] MA_MAX = 20'hFFFFF;

  logic [2:0]  state, state_nxt;
  logic [6:0]  addr_q, addr_nxt;
  logic        store_q;
  logic [19:0] wdata_q;
  logic [19:0] ds_q;
  logic [19:0] rsp_data_q;
  logic [19:0] ma_q;
  logic        viol_q;
  logic [19:0] ea;
  logic [19:0] ptr;
  logic        accept;
  logic        strobe_rd;
  logic        strobe_wr;

  assign accept = bus.req_valid && (state == S_IDLE);
  assign ea     = bus.ds_base + bus.req_addr;
  assign ptr    = ds_q + bus.mem_rdata;

  // Strobes come from registered state only; reset kills them at once so an
  // aborted store never lands in the RAM at the reset edge.
  assign strobe_rd = !rst && ((state == S_PRD) || (state == S_RD));
  assign strobe_wr = !rst && (state == S_WR);

  // Next state and active address; violating addresses never reach addr_q as a strobe target.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_nxt = ea[6:0];
          if (ea >= LIMIT)                state_nxt = S_VIOL;
          else if (bus.req_op == OP_LDD)  state_nxt = S_RD;
          else if (bus.req_op == OP_STD)  state_nxt = S_WR;
          else                            state_nxt = S_PRD;
        end
      end
      S_PRD:   state_nxt = S_PWAIT;
      S_PWAIT: begin
        if (ptr >= LIMIT) begin
          state_nxt = S_VIOL;
        end else begin
          addr_nxt  = ptr[6:0];
          state_nxt = store_q ? S_WR : S_RD;
        end
      end
      S_RD:    state_nxt = S_RWAIT;
      S_RWAIT: state_nxt = S_DONE;
      S_WR:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_VIOL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, address and request operands latched at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
      ds_q    <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      if (accept) begin
        store_q <= bus.req_op[0];
        wdata_q <= bus.req_wdata;
        ds_q    <= bus.ds_base;
      end
    end
  end

  // Response data is loaded only on entry to DONE/VIOL, so it holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q <= '0;
    end else if ((state_nxt == S_DONE) || (state_nxt == S_VIOL)) begin
      rsp_data_q <= (state == S_RWAIT) ? bus.mem_rdata : 20'd0;
    end
  end

  // Saturating count of RAM strobe cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ma_q <= '0;
    end else if ((strobe_rd || strobe_wr) && (ma_q != MA_MAX)) begin
      ma_q <= ma_q + 20'd1;
    end
  end

  // Sticky violation flag; a violation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_q <= 1'b0;
    end else if (state == S_VIOL) begin
      viol_q <= 1'b1;
    end else if (bus.viol_clear) begin
      viol_q <= 1'b0;
    end
  end

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.rsp_valid    = (state == S_DONE) || (state == S_VIOL);
  assign bus.rsp_viol     = (state == S_VIOL);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.mem_readsig  = strobe_rd;
  assign bus.mem_writesig = strobe_wr;
  assign bus.mem_control  = strobe_rd || strobe_wr;
  assign bus.mem_addr     = (strobe_rd || strobe_wr) ? addr_q : 7'd0;
  assign bus.mem_wdata    = strobe_wr ? wdata_q : 20'd0;
  assign bus.ma_count     = ma_q;
  assign bus.viol_flag    = viol_q;

endmodule
